fdiv_seq: RTL
=============

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  request; operands sampled when en=1 and busy=0.
REQ-006 SHALL have port x1  input  W  dividend, {sign, exp, man}.
REQ-007 SHALL have port x2  input  W  divisor, same format.
REQ-008 SHALL have port y  output  W  quotient, registered, held until next done.
REQ-009 SHALL have port done  output  1  single-cycle pulse, y valid.
REQ-010 SHALL have port busy  output  1  operation in flight.
REQ-011 SHALL have port exc  output  3  {invalid, divzero, overflow}, valid with done (present only under FDIV_EXC_EN).

Function
REQ-012 SHALL implement FSM IDLE -> DIV -> ROUND -> IDLE.
REQ-013 IDLE: en=1 SHALL capture x1/x2, unpack, set busy=1 next cycle, enter DIV with counter=0.
REQ-014 DIV SHALL produce one restoring-division quotient bit per cycle for exactly MAN_W+3 cycles, then enter ROUND.
REQ-015 ROUND SHALL normalise (quotient in [0.5,2): at most 1-bit left shift), round to nearest even using guard and sticky (remainder!=0), register y, pulse done=1, clear busy, return to IDLE.
REQ-016 Latency SHALL be fixed: done high in cycle MAN_W+4 after the accepting edge (27 for defaults), including special cases.
REQ-017 en while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-018 en=1 in the cycle done=1 SHALL be accepted (back-to-back throughput, one result per MAN_W+4 cycles).
REQ-019 Result exponent SHALL be e1-e2+bias with borrow from normalisation; computed in EXP_W+2-bit signed arithmetic.
REQ-020 Inputs with exp=0 SHALL be treated as signed zero (denormals flushed); results below min normal SHALL be signed zero.
REQ-021 Results above max finite after rounding SHALL be signed infinity; overflow=1.
REQ-022 Sign SHALL be sign(x1) XOR sign(x2) for all non-NaN results.
REQ-023 Finite nonzero / zero SHALL give signed infinity, divzero=1.
REQ-024 0/0, inf/inf, or any NaN operand SHALL give canonical NaN {0, all-ones exp, man MSB=1, rest 0}, invalid=1.
REQ-025 inf/finite SHALL give signed infinity; finite/inf and 0/nonzero SHALL give signed zero; exc=0.
REQ-026 Normal results SHALL be bit-exact to IEEE round-to-nearest-even (no ulp tolerance).

Reset
REQ-027 rst=1 SHALL asynchronously force FSM=IDLE, y=0, done=0, busy=0, exc=0, counter=0.
REQ-028 rst during DIV/ROUND SHALL abort; no done pulse for the aborted operation; first en after rst release accepted normally.

Configuration
REQ-029 Macro FDIV_EXC_EN defined: exc port present, flags registered with y in ROUND, cleared when next request accepted.
REQ-030 FDIV_EXC_EN undefined: exc port and flag logic absent; y, done, busy, latency identical.

Verification
REQ-031 x1=0x40C00000 (6.0), x2=0x40000000 (2.0), en one cycle -> done at cycle 27, y=0x40400000, exc=000.
REQ-032 x1=0x3F800000, x2=0x40400000 -> y=0x3EAAAAAB (round-up case), exact.
REQ-033 x1=0x3F800000, x2=0x00000000 -> y=0x7F800000, exc=010; x1=x2=0x00000000 -> y=0x7FC00000, exc=100.
REQ-034 x1=0x7F7FFFFF, x2=0x3F000000 -> y=0x7F800000, exc=001; x1=0x00800000, x2=0x40000000 -> y=0x00000000.
REQ-035 second en with different operands at cycle 5 while busy -> ignored, first result only; en at done cycle -> accepted, next done 27 cycles later.
REQ-036 rst pulse at cycle 10 of an operation -> busy=0, done never pulses, y=0; new request then completes correctly.

Source files
------------

// File: rtl/fdiv_seq_if.sv
// Request/response bundle for fdiv_seq; exc exists only when FDIV_EXC_EN is defined.
// Operands and en travel master->slave; y/done/busy(/exc) travel slave->master.
// No flow control beyond busy: en offered while busy is dropped by the divider.
interface fdiv_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         en;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] y;
  logic         done;
  logic         busy;
`ifdef FDIV_EXC_EN
  logic [2:0]   exc;

  modport master (output en, x1, x2, input y, done, busy, exc);
  modport slave  (input en, x1, x2, output y, done, busy, exc);
`else
  modport master (output en, x1, x2, input y, done, busy);
  modport slave  (input en, x1, x2, output y, done, busy);
`endif
endinterface

// File: rtl/fdiv_seq.sv
// Sequential IEEE-style divider (restoring, RNE, denormals flushed); FDIV_EXC_EN adds exc flags.
// Latency: done pulses MAN_W+4 cycles after the accepting edge, special operands included.
// Backpressure: en is taken only while idle; requests during busy are dropped, en on done is accepted.
module fdiv_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic      clk,
  input  logic      rst,
  fdiv_seq_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int XW    = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 3);

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAN_W + 2);
  localparam logic signed [XW-1:0] BIAS    = XW'(2**(EXP_W-1) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'(2**EXP_W - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [W-1:0]        QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [MAN_W+1:0]     r_rem;
  logic [MAN_W:0]       r_div;
  logic [MAN_W+2:0]     r_q;
  logic signed [XW-1:0] r_exp;
  logic                 r_sign;
  logic                 r_spc;
  logic [W-1:0]         r_spc_y;
  logic [W-1:0]         r_y;
  logic                 r_done;
  logic                 w_busy;
  logic                 w_accept;

  logic [EXP_W-1:0]     w_e1, w_e2;
  logic [MAN_W-1:0]     w_m1, w_m2;
  logic                 w_s;
  logic                 w_z1, w_z2, w_i1, w_i2, w_n1, w_n2;
  logic                 w_spc;
  logic [W-1:0]         w_spc_y;
  logic signed [XW-1:0] w_exp_d;

  logic                 w_qbit;
  logic [MAN_W:0]       w_rem_sub;

  logic                 w_norm, w_grd, w_stk, w_rnd;
  logic [MAN_W:0]       w_man;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_carry;
  logic signed [XW-1:0] w_exp_f;
  logic [W-1:0]         w_y;

`ifdef FDIV_EXC_EN
  logic [2:0]           r_spc_exc;
  logic [2:0]           r_exc;
  logic [2:0]           w_spc_exc;
  logic                 w_ovf;
`endif

  // Operand unpack and class decode, used only on the accepting edge
  assign w_e1 = bus.x1[W-2:MAN_W];
  assign w_e2 = bus.x2[W-2:MAN_W];
  assign w_m1 = bus.x1[MAN_W-1:0];
  assign w_m2 = bus.x2[MAN_W-1:0];
  assign w_s  = bus.x1[W-1] ^ bus.x2[W-1];
  assign w_z1 = (w_e1 == '0);
  assign w_z2 = (w_e2 == '0);
  assign w_i1 = (w_e1 == EXP_ONES) && (w_m1 == '0);
  assign w_i2 = (w_e2 == EXP_ONES) && (w_m2 == '0);
  assign w_n1 = (w_e1 == EXP_ONES) && (w_m1 != '0);
  assign w_n2 = (w_e2 == EXP_ONES) && (w_m2 != '0);
  assign w_exp_d = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + BIAS;
  assign w_accept = (r_state == S_IDLE) && bus.en;

  always_comb begin
    w_spc   = 1'b0;
    w_spc_y = '0;
`ifdef FDIV_EXC_EN
    w_spc_exc = 3'b000;
`endif
    if (w_n1 || w_n2 || (w_z1 && w_z2) || (w_i1 && w_i2)) begin
      w_spc   = 1'b1;
      w_spc_y = QNAN;
`ifdef FDIV_EXC_EN
      w_spc_exc = 3'b100;
`endif
    end else if (w_i1) begin
      w_spc   = 1'b1;
      w_spc_y = {w_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_z2) begin
      w_spc   = 1'b1;
      w_spc_y = {w_s, EXP_ONES, {MAN_W{1'b0}}};
`ifdef FDIV_EXC_EN
      w_spc_exc = 3'b010;
`endif
    end else if (w_z1 || w_i2) begin
      w_spc   = 1'b1;
      w_spc_y = {w_s, {(W-1){1'b0}}};
    end
  end

  // Restoring step: partial remainder always stays below twice the divisor
  assign w_qbit    = (r_rem >= {1'b0, r_div});
  assign w_rem_sub = w_qbit ? (MAN_W+1)'(r_rem - {1'b0, r_div}) : r_rem[MAN_W:0];

  // Quotient lies in [0.5,2): top bit selects whether a 1-bit left shift is needed
  assign w_norm  = r_q[MAN_W+2];
  assign w_man   = w_norm ? r_q[MAN_W+2:2] : r_q[MAN_W+1:1];
  assign w_grd   = w_norm ? r_q[1] : r_q[0];
  assign w_stk   = (w_norm && r_q[0]) || (r_rem != '0);
  assign w_rnd   = w_grd && (w_stk || w_man[0]);
  assign w_carry = w_rnd && (&w_man);
  assign w_frac  = w_man[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, w_rnd};
  assign w_exp_f = r_exp - XW'(!w_norm) + XW'(w_carry);

  always_comb begin
    if (r_spc)
      w_y = r_spc_y;
    else if (w_exp_f >= EXP_MAX)
      w_y = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (w_exp_f <= EXP_ZERO)
      w_y = {r_sign, {(W-1){1'b0}}};
    else
      w_y = {r_sign, w_exp_f[EXP_W-1:0], w_frac};
  end

`ifdef FDIV_EXC_EN
  assign w_ovf = !r_spc && (w_exp_f >= EXP_MAX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.en) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == CNT_LAST) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_spc     <= 1'b0;
      r_spc_y   <= '0;
      r_y       <= '0;
      r_done    <= 1'b0;
`ifdef FDIV_EXC_EN
      r_spc_exc <= '0;
      r_exc     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_rem   <= {1'b0, 1'b1, w_m1};
        r_div   <= {1'b1, w_m2};
        r_q     <= '0;
        r_cnt   <= '0;
        r_exp   <= w_exp_d;
        r_sign  <= w_s;
        r_spc   <= w_spc;
        r_spc_y <= w_spc_y;
`ifdef FDIV_EXC_EN
        r_spc_exc <= w_spc_exc;
        r_exc     <= '0;
`endif
      end else if (r_state == S_DIV) begin
        r_q   <= {r_q[MAN_W+1:0], w_qbit};
        r_rem <= {w_rem_sub, 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_ROUND) begin
        r_y    <= w_y;
        r_done <= 1'b1;
        r_cnt  <= '0;
`ifdef FDIV_EXC_EN
        r_exc  <= r_spc ? r_spc_exc : {2'b00, w_ovf};
`endif
      end
    end
  end

  assign bus.y    = r_y;
  assign bus.done = r_done;
  assign bus.busy = w_busy;
`ifdef FDIV_EXC_EN
  assign bus.exc  = r_exc;
`endif
endmodule
